// File: rtl/ibex_rf_wb_buffer.sv
// Writeback buffer in front of the latch-based register file write port.
// Merges the LSU and EX writeback streams into at most one RF write per cycle
// through a small in-order FIFO, and forwards queued and just-issued write data
// to both read ports to cover the latch RF's one-cycle visibility delay.
module ibex_rf_wb_buffer #(
  parameter int unsigned DataWidth = 32,
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned Depth     = 2
) (
  input  logic                 clk_int,
  input  logic                 rst_ni,

  input  logic                 ex_valid_i,
  input  logic [4:0]           ex_addr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  output logic                 ex_ready_o,

  input  logic                 lsu_valid_i,
  input  logic [4:0]           lsu_addr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 lsu_ready_o,

  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,

  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 fwd_a_valid_o,
  output logic [DataWidth-1:0] fwd_a_data_o,
  output logic                 fwd_b_valid_o,
  output logic [DataWidth-1:0] fwd_b_data_o,

  output logic                 empty_o
);

  // Only the low AW address bits are architecturally meaningful.
  localparam int unsigned AW = RV32E ? 4 : 5;
  localparam int unsigned PW = $clog2(Depth);
  localparam int unsigned CW = $clog2(Depth + 1);

  logic [AW-1:0]        mem_addr_q [Depth];
  logic [DataWidth-1:0] mem_data_q [Depth];
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        ex_slot_s;
  logic [CW-1:0]        count_q, count_d;

  logic                 last_valid_q;
  logic [AW-1:0]        last_addr_q;
  logic [DataWidth-1:0] last_data_q;

  logic [CW:0]          free_s;
  logic                 pop_s;
  logic                 lsu_push_s;
  logic                 ex_push_s;
  logic [AW-1:0]        ex_addr_s, lsu_addr_s, raddr_a_s, raddr_b_s;
  logic                 unused_addr_bits_s;

  assign ex_addr_s  = ex_addr_i[AW-1:0];
  assign lsu_addr_s = lsu_addr_i[AW-1:0];
  assign raddr_a_s  = raddr_a_i[AW-1:0];
  assign raddr_b_s  = raddr_b_i[AW-1:0];
  // Upper address bit is ignored in the 16-register configuration.
  assign unused_addr_bits_s = ^{ex_addr_i[4], lsu_addr_i[4], raddr_a_i[4], raddr_b_i[4]};

  // A valid FIFO entry or the last-issued write matches a read address (x0 never matches).
  function automatic logic addr_hit(input logic vld, input logic [AW-1:0] a,
                                    input logic [AW-1:0] ra);
    return vld && (ra != {AW{1'b0}}) && (a == ra);
  endfunction

  // Acceptance and pointer/occupancy bookkeeping; the head slot counts as free when it pops now.
  always_comb begin
    pop_s       = (count_q != {CW{1'b0}});
    free_s      = (CW+1)'(Depth) - {1'b0, count_q} + {{CW{1'b0}}, pop_s};
    lsu_ready_o = (free_s >= (CW+1)'(32'd1));
    ex_ready_o  = (free_s >= (lsu_valid_i ? (CW+1)'(32'd2) : (CW+1)'(32'd1)));
    lsu_push_s  = lsu_valid_i && lsu_ready_o && (lsu_addr_s != {AW{1'b0}});
    ex_push_s   = ex_valid_i && ex_ready_o && (ex_addr_s != {AW{1'b0}});
    ex_slot_s   = wr_ptr_q + PW'(lsu_push_s);
    wr_ptr_d    = wr_ptr_q + PW'(lsu_push_s) + PW'(ex_push_s);
    rd_ptr_d    = rd_ptr_q + PW'(pop_s);
    count_d     = count_q + CW'(lsu_push_s) + CW'(ex_push_s) - CW'(pop_s);
  end

  // RF write port is driven straight from the FIFO head; zero when nothing is queued.
  always_comb begin
    rf_we_o = (count_q != {CW{1'b0}});
    if (rf_we_o) begin
      rf_waddr_o = 5'(mem_addr_q[rd_ptr_q]);
      rf_wdata_o = mem_data_q[rd_ptr_q];
    end else begin
      rf_waddr_o = 5'd0;
      rf_wdata_o = '0;
    end
  end

  assign empty_o = (count_q == {CW{1'b0}}) && !last_valid_q;

  // Forwarding: start from last-issued, then walk the FIFO oldest to youngest so younger wins.
  always_comb begin
    fwd_a_valid_o = addr_hit(last_valid_q, last_addr_q, raddr_a_s);
    fwd_a_data_o  = fwd_a_valid_o ? last_data_q : '0;
    fwd_b_valid_o = addr_hit(last_valid_q, last_addr_q, raddr_b_s);
    fwd_b_data_o  = fwd_b_valid_o ? last_data_q : '0;
    for (int unsigned k = 0; k < Depth; k++) begin
      if (addr_hit(CW'(k) < count_q, mem_addr_q[rd_ptr_q + PW'(k)], raddr_a_s)) begin
        fwd_a_valid_o = 1'b1;
        fwd_a_data_o  = mem_data_q[rd_ptr_q + PW'(k)];
      end else begin
        fwd_a_valid_o = fwd_a_valid_o;
      end
      if (addr_hit(CW'(k) < count_q, mem_addr_q[rd_ptr_q + PW'(k)], raddr_b_s)) begin
        fwd_b_valid_o = 1'b1;
        fwd_b_data_o  = mem_data_q[rd_ptr_q + PW'(k)];
      end else begin
        fwd_b_valid_o = fwd_b_valid_o;
      end
    end
  end

  // Control state: pointers, occupancy and the one-cycle last-issued register.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q     <= {PW{1'b0}};
      wr_ptr_q     <= {PW{1'b0}};
      count_q      <= {CW{1'b0}};
      last_valid_q <= 1'b0;
      last_addr_q  <= {AW{1'b0}};
      last_data_q  <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      last_valid_q <= pop_s;
      if (pop_s) begin
        last_addr_q <= mem_addr_q[rd_ptr_q];
        last_data_q <= mem_data_q[rd_ptr_q];
      end
    end
  end

  // FIFO storage: LSU lands first (older), EX in the following slot.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_addr_q[i] <= {AW{1'b0}};
        mem_data_q[i] <= '0;
      end
    end else begin
      if (lsu_push_s) begin
        mem_addr_q[wr_ptr_q] <= lsu_addr_s;
        mem_data_q[wr_ptr_q] <= lsu_wdata_i;
      end
      if (ex_push_s) begin
        mem_addr_q[ex_slot_s] <= ex_addr_s;
        mem_data_q[ex_slot_s] <= ex_wdata_i;
      end
    end
  end

endmodule

// File: tb/tb_ibex_rf_wb_buffer.sv
// Self-checking bench for ibex_rf_wb_buffer: directed vector table, randomized
// traffic against a queue-based reference model, reset and RV32E sequences.
module tb_ibex_rf_wb_buffer;

  localparam int DEPTH = 2;

  logic        clk_int = 1'b0;
  logic        rst_ni;
  logic        ex_valid_i, lsu_valid_i;
  logic [4:0]  ex_addr_i, lsu_addr_i, raddr_a_i, raddr_b_i;
  logic [31:0] ex_wdata_i, lsu_wdata_i;

  logic        ex_ready_o, lsu_ready_o, rf_we_o, fwd_a_valid_o, fwd_b_valid_o, empty_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o, fwd_a_data_o, fwd_b_data_o;

  logic        e_ex_ready, e_lsu_ready, e_we, e_fa_v, e_fb_v, e_empty;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata, e_fa_d, e_fb_d;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_int = ~clk_int;

  ibex_rf_wb_buffer #(.DataWidth(32), .RV32E(1'b0), .Depth(DEPTH)) dut (
    .clk_int(clk_int), .rst_ni(rst_ni),
    .ex_valid_i(ex_valid_i), .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i), .ex_ready_o(ex_ready_o),
    .lsu_valid_i(lsu_valid_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_ready_o(lsu_ready_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
    .fwd_a_valid_o(fwd_a_valid_o), .fwd_a_data_o(fwd_a_data_o),
    .fwd_b_valid_o(fwd_b_valid_o), .fwd_b_data_o(fwd_b_data_o),
    .empty_o(empty_o)
  );

  ibex_rf_wb_buffer #(.DataWidth(32), .RV32E(1'b1), .Depth(DEPTH)) dut_e (
    .clk_int(clk_int), .rst_ni(rst_ni),
    .ex_valid_i(ex_valid_i), .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i), .ex_ready_o(e_ex_ready),
    .lsu_valid_i(lsu_valid_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_ready_o(e_lsu_ready),
    .rf_we_o(e_we), .rf_waddr_o(e_waddr), .rf_wdata_o(e_wdata),
    .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
    .fwd_a_valid_o(e_fa_v), .fwd_a_data_o(e_fa_d),
    .fwd_b_valid_o(e_fb_v), .fwd_b_data_o(e_fb_d),
    .empty_o(e_empty)
  );

  typedef struct {
    logic        ex_v;  logic [4:0] ex_a;  logic [31:0] ex_d;
    logic        lsu_v; logic [4:0] lsu_a; logic [31:0] lsu_d;
    logic [4:0]  ra;    logic [4:0] rb;
    logic        x_exr; logic x_lsr; logic x_we; logic [4:0] x_wa; logic [31:0] x_wd;
    logic        x_fav; logic [31:0] x_fad; logic x_fbv; logic [31:0] x_fbd; logic x_empty;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic ex_v, input logic [4:0] ex_a, input logic [31:0] ex_d,
    input logic lsu_v, input logic [4:0] lsu_a, input logic [31:0] lsu_d,
    input logic [4:0] ra, input logic [4:0] rb,
    input logic exr, input logic lsr, input logic we, input logic [4:0] wa, input logic [31:0] wd,
    input logic fav, input logic [31:0] fad, input logic fbv, input logic [31:0] fbd, input logic emp);
    vec_t v;
    v.ex_v = ex_v; v.ex_a = ex_a; v.ex_d = ex_d;
    v.lsu_v = lsu_v; v.lsu_a = lsu_a; v.lsu_d = lsu_d;
    v.ra = ra; v.rb = rb;
    v.x_exr = exr; v.x_lsr = lsr; v.x_we = we; v.x_wa = wa; v.x_wd = wd;
    v.x_fav = fav; v.x_fad = fad; v.x_fbv = fbv; v.x_fbd = fbd; v.x_empty = emp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic exv, input logic [4:0] exa, input logic [31:0] exd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld,
                       input logic [4:0] ra, input logic [4:0] rb);
    ex_valid_i = exv; ex_addr_i = exa; ex_wdata_i = exd;
    lsu_valid_i = lv; lsu_addr_i = la; lsu_wdata_i = ld;
    raddr_a_i = ra; raddr_b_i = rb;
  endtask

  // Reference model: program-ordered queue of pending writes plus last-issued write.
  logic [4:0]  mq_a [$];
  logic [31:0] mq_d [$];
  logic        m_last_v = 1'b0;
  logic [4:0]  m_last_a = 5'd0;
  logic [31:0] m_last_d = 32'd0;
  int          n_accepted = 0;
  int          n_writes = 0;

  function automatic logic [32:0] model_fwd(input logic [4:0] ra);
    if (ra == 5'd0) return 33'd0;
    for (int i = mq_a.size() - 1; i >= 0; i--)
      if (mq_a[i] == ra) return {1'b1, mq_d[i]};
    if (m_last_v && m_last_a == ra) return {1'b1, m_last_d};
    return 33'd0;
  endfunction

  task automatic model_step();
    int sz, free_slots;
    logic exp_lr, exp_er;
    logic [32:0] fa, fb;
    sz = mq_a.size();
    free_slots = DEPTH - sz + ((sz != 0) ? 1 : 0);
    exp_lr = (free_slots >= 1);
    exp_er = (free_slots >= (lsu_valid_i ? 2 : 1));
    fa = model_fwd(raddr_a_i);
    fb = model_fwd(raddr_b_i);
    chk("rnd_lsu_ready", 32'(lsu_ready_o), 32'(exp_lr));
    chk("rnd_ex_ready", 32'(ex_ready_o), 32'(exp_er));
    chk("rnd_we", 32'(rf_we_o), 32'(sz != 0));
    chk("rnd_waddr", 32'(rf_waddr_o), (sz != 0) ? 32'(mq_a[0]) : 32'd0);
    chk("rnd_wdata", rf_wdata_o, (sz != 0) ? mq_d[0] : 32'd0);
    chk("rnd_fwd_a_valid", 32'(fwd_a_valid_o), 32'(fa[32]));
    chk("rnd_fwd_a_data", fwd_a_data_o, fa[31:0]);
    chk("rnd_fwd_b_valid", 32'(fwd_b_valid_o), 32'(fb[32]));
    chk("rnd_fwd_b_data", fwd_b_data_o, fb[31:0]);
    chk("rnd_empty", 32'(empty_o), 32'((sz == 0) && !m_last_v));
    if (rf_we_o) n_writes++;
    if (sz != 0) begin
      m_last_v = 1'b1; m_last_a = mq_a.pop_front(); m_last_d = mq_d.pop_front();
    end else begin
      m_last_v = 1'b0;
    end
    if (lsu_valid_i && exp_lr && lsu_addr_i != 5'd0) begin
      mq_a.push_back(lsu_addr_i); mq_d.push_back(lsu_wdata_i); n_accepted++;
    end
    if (ex_valid_i && exp_er && ex_addr_i != 5'd0) begin
      mq_a.push_back(ex_addr_i); mq_d.push_back(ex_wdata_i); n_accepted++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ex_v ex_a ex_d | lsu_v lsu_a lsu_d | ra rb | exr lsr we wa wd | fav fad | fbv fbd | empty
    tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,     5, 0, 1, 1, 0, 0, 0,            0, 0,            0, 0,    1);
    tbl[1]  = mk(0, 0, 0,            0, 0, 0,     5, 0, 1, 1, 1, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 0,    0);
    tbl[2]  = mk(0, 0, 0,            0, 0, 0,     5, 0, 1, 1, 0, 0, 0,            1, 32'hDEADBEEF, 0, 0,    0);
    tbl[3]  = mk(0, 0, 0,            0, 0, 0,     5, 0, 1, 1, 0, 0, 0,            0, 0,            0, 0,    1);
    tbl[4]  = mk(1, 3, 32'h22,       1, 3, 32'h11, 0, 3, 1, 1, 0, 0, 0,           0, 0,            0, 0,    1);
    tbl[5]  = mk(0, 0, 0,            0, 0, 0,     0, 3, 1, 1, 1, 3, 32'h11,       0, 0,            1, 32'h22, 0);
    tbl[6]  = mk(0, 0, 0,            0, 0, 0,     0, 3, 1, 1, 1, 3, 32'h22,       0, 0,            1, 32'h22, 0);
    tbl[7]  = mk(0, 0, 0,            0, 0, 0,     0, 3, 1, 1, 0, 0, 0,            0, 0,            1, 32'h22, 0);
    tbl[8]  = mk(0, 0, 0,            0, 0, 0,     0, 3, 1, 1, 0, 0, 0,            0, 0,            0, 0,    1);
    tbl[9]  = mk(1, 0, 32'hFFFFFFFF, 0, 0, 0,     0, 0, 1, 1, 0, 0, 0,            0, 0,            0, 0,    1);
    tbl[10] = mk(0, 0, 0,            0, 0, 0,     0, 0, 1, 1, 0, 0, 0,            0, 0,            0, 0,    1);
    tbl[11] = mk(1, 8, 32'h2,        1, 7, 32'h1, 0, 0, 1, 1, 0, 0, 0,            0, 0,            0, 0,    1);
    tbl[12] = mk(1, 10, 32'h4,       1, 9, 32'h3, 7, 8, 0, 1, 1, 7, 32'h1,        1, 32'h1,        1, 32'h2, 0);
    tbl[13] = mk(0, 0, 0,            0, 0, 0,    10, 8, 1, 1, 1, 8, 32'h2,        0, 0,            1, 32'h2, 0);
    tbl[14] = mk(0, 0, 0,            0, 0, 0,     9, 8, 1, 1, 1, 9, 32'h3,        1, 32'h3,        1, 32'h2, 0);
    tbl[15] = mk(0, 0, 0,            0, 0, 0,     9, 8, 1, 1, 0, 0, 0,            1, 32'h3,        0, 0,    0);
    tbl[16] = mk(0, 0, 0,            0, 0, 0,     9, 8, 1, 1, 0, 0, 0,            0, 0,            0, 0,    1);
    tbl[17] = mk(1, 2, 32'h6,        1, 1, 32'h5, 0, 0, 1, 1, 0, 0, 0,            0, 0,            0, 0,    1);
    tbl[18] = mk(1, 4, 32'h7,        0, 0, 0,     1, 2, 1, 1, 1, 1, 32'h5,        1, 32'h5,        1, 32'h6, 0);
    tbl[19] = mk(0, 0, 0,            0, 0, 0,     4, 1, 1, 1, 1, 2, 32'h6,        1, 32'h7,        1, 32'h5, 0);
    tbl[20] = mk(0, 0, 0,            0, 0, 0,     4, 2, 1, 1, 1, 4, 32'h7,        1, 32'h7,        1, 32'h6, 0);
    tbl[21] = mk(0, 0, 0,            0, 0, 0,     4, 2, 1, 1, 0, 0, 0,            1, 32'h7,        0, 0,    0);
    tbl[22] = mk(0, 0, 0,            0, 0, 0,     4, 2, 1, 1, 0, 0, 0,            0, 0,            0, 0,    1);

    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk_int);
    #1;
    chk("reset_we", 32'(rf_we_o), 32'd0);
    chk("reset_empty", 32'(empty_o), 32'd1);
    chk("reset_ex_ready", 32'(ex_ready_o), 32'd1);
    chk("reset_lsu_ready", 32'(lsu_ready_o), 32'd1);
    chk("reset_fwd_a_valid", 32'(fwd_a_valid_o), 32'd0);
    @(negedge clk_int);
    rst_ni = 1'b1;

    // Directed vector table.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk_int);
      drive(tbl[i].ex_v, tbl[i].ex_a, tbl[i].ex_d, tbl[i].lsu_v, tbl[i].lsu_a, tbl[i].lsu_d,
            tbl[i].ra, tbl[i].rb);
      #1;
      chk("vec_ex_ready", 32'(ex_ready_o), 32'(tbl[i].x_exr));
      chk("vec_lsu_ready", 32'(lsu_ready_o), 32'(tbl[i].x_lsr));
      chk("vec_we", 32'(rf_we_o), 32'(tbl[i].x_we));
      chk("vec_waddr", 32'(rf_waddr_o), 32'(tbl[i].x_wa));
      chk("vec_wdata", rf_wdata_o, tbl[i].x_wd);
      chk("vec_fwd_a_valid", 32'(fwd_a_valid_o), 32'(tbl[i].x_fav));
      chk("vec_fwd_a_data", fwd_a_data_o, tbl[i].x_fad);
      chk("vec_fwd_b_valid", 32'(fwd_b_valid_o), 32'(tbl[i].x_fbv));
      chk("vec_fwd_b_data", fwd_b_data_o, tbl[i].x_fbd);
      chk("vec_empty", 32'(empty_o), 32'(tbl[i].x_empty));
    end

    // Randomized dual-source traffic against the reference model, then drain.
    for (int c = 0; c < 300; c++) begin
      @(negedge clk_int);
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      #1;
      model_step();
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_int);
      drive(0, 0, 0, 0, 0, 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      #1;
      model_step();
    end
    chk("rnd_write_count", 32'(n_writes), 32'(n_accepted));
    chk("rnd_model_drained", 32'(mq_a.size()), 32'd0);

    // Reset in the middle of traffic with two entries pending.
    @(negedge clk_int);
    drive(1, 12, 32'hB, 1, 11, 32'hA, 0, 0);
    @(negedge clk_int);
    drive(0, 0, 0, 0, 0, 0, 11, 12);
    #1;
    chk("rst_pre_we", 32'(rf_we_o), 32'd1);
    chk("rst_pre_waddr", 32'(rf_waddr_o), 32'd11);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_we", 32'(rf_we_o), 32'd0);
    chk("rst_mid_waddr", 32'(rf_waddr_o), 32'd0);
    chk("rst_mid_wdata", rf_wdata_o, 32'd0);
    chk("rst_mid_empty", 32'(empty_o), 32'd1);
    chk("rst_mid_fwd_a", 32'(fwd_a_valid_o), 32'd0);
    chk("rst_mid_fwd_b", 32'(fwd_b_valid_o), 32'd0);
    @(negedge clk_int);
    rst_ni = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_int);
      #1;
      chk("rst_post_we", 32'(rf_we_o), 32'd0);
      chk("rst_post_empty", 32'(empty_o), 32'd1);
      chk("rst_post_fwd_a", 32'(fwd_a_valid_o), 32'd0);
    end

    // RV32E: only addr[3:0] stored/compared.
    @(negedge clk_int);
    drive(1, 5'h13, 32'h55, 0, 0, 0, 0, 0);
    @(negedge clk_int);
    drive(0, 0, 0, 0, 0, 0, 5'h03, 0);
    #1;
    chk("e_we", 32'(e_we), 32'd1);
    chk("e_waddr", 32'(e_waddr), 32'h3);
    chk("e_fwd_a_valid", 32'(e_fa_v), 32'd1);
    chk("e_fwd_a_data", e_fa_d, 32'h55);
    chk("full_waddr_13", 32'(rf_waddr_o), 32'h13);
    chk("full_fwd_a_no_alias", 32'(fwd_a_valid_o), 32'd0);

    @(negedge clk_int);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
